// File: rtl/bw_r_cm_prm.sv
// bw_r_cm_prm: parametrised content-addressable miss/fill tag buffer.
// Requests are captured at one edge and acted on at the next. Lookup and
// read results come out of registers at that same edge. Lookups and reads
// see the array as it was before any write that completes on that edge.
module bw_r_cm_prm #(
  parameter int DEPTH  = 16,
  parameter int AW     = 4,
  parameter int WIDTH  = 40,
  parameter int KEY_LO = 8,
  parameter int IDX_HI = 17
) (
  input  logic                    rclk,
  input  logic                    rst,
  input  logic                    sehold,
  input  logic                    rst_tri_en,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_adr,
  input  logic [WIDTH-1:0]        din,
  input  logic                    rd_en,
  input  logic [AW-1:0]           rd_adr,
  output logic [WIDTH-1:0]        dout,
  output logic                    rd_vld,
  input  logic                    inv_en,
  input  logic [AW-1:0]           inv_adr,
  input  logic                    inv_all,
  input  logic                    lookup_en,
  input  logic [WIDTH-KEY_LO-1:0] key,
  output logic [DEPTH-1:0]        match,
  output logic [DEPTH-1:0]        match_idx,
  output logic                    hit,
  output logic [AW-1:0]           hit_adr,
  output logic                    multi_hit,
  output logic                    lk_wr_coll
);

  localparam int KW = WIDTH - KEY_LO;
  localparam int IW = IDX_HI - KEY_LO + 1;

  logic                 wr_en_d1, rd_en_d1, inv_en_d1, inv_all_d1, lookup_en_d1;
  logic [AW-1:0]        wr_adr_d1, rd_adr_d1, inv_adr_d1;
  logic [WIDTH-1:0]     din_d1;
  logic [KW-1:0]        key_d1;

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [DEPTH-1:0]     vld;

  logic [DEPTH-1:0]     match_nxt, match_idx_nxt;
  logic [AW-1:0]        hit_adr_nxt;
  logic                 multi_hit_nxt, lk_wr_coll_nxt;

  // Capture request enables; reset drops anything pending, sehold freezes them
  always_ff @(posedge rclk) begin
    if (rst) begin
      wr_en_d1     <= 1'b0;
      rd_en_d1     <= 1'b0;
      inv_en_d1    <= 1'b0;
      inv_all_d1   <= 1'b0;
      lookup_en_d1 <= 1'b0;
    end else if (!sehold) begin
      wr_en_d1     <= wr_en;
      rd_en_d1     <= rd_en;
      inv_en_d1    <= inv_en;
      inv_all_d1   <= inv_all;
      lookup_en_d1 <= lookup_en;
    end
  end

  // Capture addresses, data and key; these are never reset
  always_ff @(posedge rclk) begin
    if (!sehold) begin
      wr_adr_d1  <= wr_adr;
      rd_adr_d1  <= rd_adr;
      inv_adr_d1 <= inv_adr;
      din_d1     <= din;
      key_d1     <= key;
    end
  end

  // Array data write; scan tri-state blocks it, data itself has no reset
  always_ff @(posedge rclk) begin
    if (!rst && wr_en_d1 && !rst_tri_en) begin
      mem[wr_adr_d1] <= din_d1;
    end
  end

  // Valid bits: a write sets, invalidates are ordered last so they win
  always_ff @(posedge rclk) begin
    if (rst) begin
      vld <= '0;
    end else if (!rst_tri_en) begin
      if (wr_en_d1) vld[wr_adr_d1] <= 1'b1;
      if (inv_all_d1) vld <= '0;
      else if (inv_en_d1) vld[inv_adr_d1] <= 1'b0;
    end
  end

  // Compare captured key against the pre-write array and encode the result
  always_comb begin
    match_nxt     = '0;
    match_idx_nxt = '0;
    hit_adr_nxt   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match_nxt[i]     = lookup_en_d1 & vld[i] & (mem[i][WIDTH-1:KEY_LO] == key_d1);
      match_idx_nxt[i] = lookup_en_d1 & vld[i] & (mem[i][IDX_HI:KEY_LO] == key_d1[IW-1:0]);
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (match_nxt[i]) hit_adr_nxt = AW'(i);
    end
    multi_hit_nxt  = |(match_nxt & (match_nxt - DEPTH'(1)));
    lk_wr_coll_nxt = lookup_en_d1 & wr_en_d1 & ~rst_tri_en & match_nxt[wr_adr_d1];
  end

  // Register lookup results; an idle lookup cycle drives them all to zero
  always_ff @(posedge rclk) begin
    if (rst) begin
      match      <= '0;
      match_idx  <= '0;
      hit        <= 1'b0;
      hit_adr    <= '0;
      multi_hit  <= 1'b0;
      lk_wr_coll <= 1'b0;
    end else begin
      match      <= match_nxt;
      match_idx  <= match_idx_nxt;
      hit        <= |match_nxt;
      hit_adr    <= hit_adr_nxt;
      multi_hit  <= multi_hit_nxt;
      lk_wr_coll <= lk_wr_coll_nxt;
    end
  end

  // Registered read port; holds its last result when no read is pending
  always_ff @(posedge rclk) begin
    if (rst) begin
      dout   <= '0;
      rd_vld <= 1'b0;
    end else if (rd_en_d1) begin
      if (rst_tri_en) begin
        dout   <= '1;
        rd_vld <= 1'b0;
      end else begin
        dout   <= mem[rd_adr_d1];
        rd_vld <= vld[rd_adr_d1];
      end
    end
  end

endmodule

// File: tb/tb_bw_r_cm_prm.sv
// tb_bw_r_cm_prm: directed bench for the tag CAM, default and wide configs.
module tb_bw_r_cm_prm;

  logic        rclk = 1'b0;
  logic        rst = 1'b1, sehold = 1'b0, rst_tri_en = 1'b0;

  logic        wr_en = 1'b0, rd_en = 1'b0, inv_en = 1'b0, inv_all = 1'b0, lookup_en = 1'b0;
  logic [3:0]  wr_adr = '0, rd_adr = '0, inv_adr = '0;
  logic [39:0] din = '0;
  logic [31:0] key = '0;
  logic [39:0] dout;
  logic        rd_vld, hit, multi_hit, lk_wr_coll;
  logic [15:0] match, match_idx;
  logic [3:0]  hit_adr;

  logic        wr_en2 = 1'b0, rd_en2 = 1'b0, inv_en2 = 1'b0, inv_all2 = 1'b0, lookup_en2 = 1'b0;
  logic [4:0]  wr_adr2 = '0, rd_adr2 = '0, inv_adr2 = '0;
  logic [47:0] din2 = '0;
  logic [41:0] key2 = '0;
  logic [47:0] dout2;
  logic        rd_vld2, hit2, multi_hit2, lk_wr_coll2;
  logic [31:0] match2, match_idx2;
  logic [4:0]  hit_adr2;

  int n_vectors = 0;
  int n_miscompares = 0;

  logic [47:0] tag_a;
  logic [47:0] tag_b;

  always #5 rclk = ~rclk;

  bw_r_cm_prm u_dut (
    .rclk(rclk), .rst(rst), .sehold(sehold), .rst_tri_en(rst_tri_en),
    .wr_en(wr_en), .wr_adr(wr_adr), .din(din),
    .rd_en(rd_en), .rd_adr(rd_adr), .dout(dout), .rd_vld(rd_vld),
    .inv_en(inv_en), .inv_adr(inv_adr), .inv_all(inv_all),
    .lookup_en(lookup_en), .key(key), .match(match), .match_idx(match_idx),
    .hit(hit), .hit_adr(hit_adr), .multi_hit(multi_hit), .lk_wr_coll(lk_wr_coll)
  );

  bw_r_cm_prm #(.DEPTH(32), .AW(5), .WIDTH(48), .KEY_LO(6), .IDX_HI(15)) u_dut2 (
    .rclk(rclk), .rst(rst), .sehold(sehold), .rst_tri_en(rst_tri_en),
    .wr_en(wr_en2), .wr_adr(wr_adr2), .din(din2),
    .rd_en(rd_en2), .rd_adr(rd_adr2), .dout(dout2), .rd_vld(rd_vld2),
    .inv_en(inv_en2), .inv_adr(inv_adr2), .inv_all(inv_all2),
    .lookup_en(lookup_en2), .key(key2), .match(match2), .match_idx(match_idx2),
    .hit(hit2), .hit_adr(hit_adr2), .multi_hit(multi_hit2), .lk_wr_coll(lk_wr_coll2)
  );

  // Advance one rising edge, then drop every request so each is a one-cycle pulse
  task automatic applyStimulus();
    @(posedge rclk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; inv_en = 1'b0; inv_all = 1'b0; lookup_en = 1'b0;
    wr_en2 = 1'b0; rd_en2 = 1'b0; inv_en2 = 1'b0; inv_all2 = 1'b0; lookup_en2 = 1'b0;
  endtask

  // Compare one observed value with its hand-computed expectation
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    // Reset state
    applyStimulus();
    applyStimulus();
    rst = 1'b0;
    checkOutput("rst_dout", 64'(dout), 64'h0);
    checkOutput("rst_rd_vld", 64'(rd_vld), 64'h0);
    checkOutput("rst_match", 64'(match), 64'h0);
    checkOutput("rst_hit", 64'(hit), 64'h0);

    // Single write then lookup
    wr_en = 1'b1; wr_adr = 4'd3; din = 40'hAB_CDEF_0100;
    applyStimulus();
    lookup_en = 1'b1; key = 32'hABCDEF01;
    applyStimulus();
    applyStimulus();
    checkOutput("t1_match", 64'(match), 64'h0008);
    checkOutput("t1_hit", 64'(hit), 64'h1);
    checkOutput("t1_hit_adr", 64'(hit_adr), 64'h3);
    checkOutput("t1_multi", 64'(multi_hit), 64'h0);
    checkOutput("t1_match_idx", 64'(match_idx), 64'h0008);

    // Same tag in two entries, then invalidate the lower one
    wr_en = 1'b1; wr_adr = 4'd5; din = 40'h12_3456_7800;
    applyStimulus();
    wr_en = 1'b1; wr_adr = 4'd9; din = 40'h12_3456_7800;
    applyStimulus();
    lookup_en = 1'b1; key = 32'h12345678;
    applyStimulus();
    applyStimulus();
    checkOutput("t2_match", 64'(match), 64'h0220);
    checkOutput("t2_hit_adr", 64'(hit_adr), 64'h5);
    checkOutput("t2_multi", 64'(multi_hit), 64'h1);
    inv_en = 1'b1; inv_adr = 4'd5;
    applyStimulus();
    lookup_en = 1'b1; key = 32'h12345678;
    applyStimulus();
    applyStimulus();
    checkOutput("t2_inv_match", 64'(match), 64'h0200);
    checkOutput("t2_inv_hit_adr", 64'(hit_adr), 64'h9);
    checkOutput("t2_inv_multi", 64'(multi_hit), 64'h0);

    // Lookup colliding with a write to the matching entry
    wr_en = 1'b1; wr_adr = 4'd2; din = 40'h55_6677_8800;
    applyStimulus();
    applyStimulus();
    wr_en = 1'b1; wr_adr = 4'd2; din = 40'h99_AABB_CC00;
    lookup_en = 1'b1; key = 32'h55667788;
    applyStimulus();
    applyStimulus();
    checkOutput("t3_coll_match", 64'(match), 64'h0004);
    checkOutput("t3_coll_flag", 64'(lk_wr_coll), 64'h1);
    lookup_en = 1'b1; key = 32'h55667788;
    applyStimulus();
    applyStimulus();
    checkOutput("t3_old_match", 64'(match), 64'h0);
    checkOutput("t3_old_coll", 64'(lk_wr_coll), 64'h0);
    lookup_en = 1'b1; key = 32'h99AABBCC;
    applyStimulus();
    applyStimulus();
    checkOutput("t3_new_match", 64'(match), 64'h0004);

    // Read concurrent with a write to the same entry returns old data
    wr_en = 1'b1; wr_adr = 4'd4; din = 40'h01_0203_0400;
    applyStimulus();
    applyStimulus();
    rd_en = 1'b1; rd_adr = 4'd4;
    wr_en = 1'b1; wr_adr = 4'd4; din = 40'h0A_0B0C_0D00;
    applyStimulus();
    applyStimulus();
    checkOutput("t4_dout_old", 64'(dout), 64'h01_0203_0400);
    checkOutput("t4_rd_vld", 64'(rd_vld), 64'h1);
    rd_en = 1'b1; rd_adr = 4'd4;
    applyStimulus();
    applyStimulus();
    checkOutput("t4_dout_new", 64'(dout), 64'h0A_0B0C_0D00);
    applyStimulus();
    checkOutput("t4_dout_hold", 64'(dout), 64'h0A_0B0C_0D00);

    // Scan tri-state blocks the write and forces read data high
    wr_en = 1'b1; wr_adr = 4'd0; din = 40'h11_1111_1100;
    applyStimulus();
    applyStimulus();
    rst_tri_en = 1'b1;
    wr_en = 1'b1; wr_adr = 4'd0; din = 40'h22_2222_2200;
    rd_en = 1'b1; rd_adr = 4'd0;
    applyStimulus();
    applyStimulus();
    checkOutput("t5_tri_dout", 64'(dout), 64'hFF_FFFF_FFFF);
    checkOutput("t5_tri_rd_vld", 64'(rd_vld), 64'h0);
    rst_tri_en = 1'b0;
    rd_en = 1'b1; rd_adr = 4'd0;
    applyStimulus();
    applyStimulus();
    checkOutput("t5_entry0_kept", 64'(dout), 64'h11_1111_1100);
    checkOutput("t5_entry0_vld", 64'(rd_vld), 64'h1);

    // Fill every entry, confirm, then reset with a lookup pending
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_adr = 4'(i); din = {32'hC000_0000 + 32'(i), 8'h00};
      applyStimulus();
    end
    lookup_en = 1'b1; key = 32'hC000_0007;
    applyStimulus();
    applyStimulus();
    checkOutput("t6_full_match", 64'(match), 64'h0080);
    checkOutput("t6_full_hit_adr", 64'(hit_adr), 64'h7);
    lookup_en = 1'b1; key = 32'hC000_0007;
    applyStimulus();
    rst = 1'b1;
    lookup_en = 1'b1; key = 32'hC000_0007;
    applyStimulus();
    rst = 1'b0;
    checkOutput("t6_rst_match", 64'(match), 64'h0);
    checkOutput("t6_rst_hit", 64'(hit), 64'h0);
    checkOutput("t6_rst_match_idx", 64'(match_idx), 64'h0);
    applyStimulus();
    checkOutput("t6_dropped_hit", 64'(hit), 64'h0);
    rd_en = 1'b1; rd_adr = 4'd7;
    lookup_en = 1'b1; key = 32'hC000_0007;
    applyStimulus();
    applyStimulus();
    checkOutput("t6_post_hit", 64'(hit), 64'h0);
    checkOutput("t6_post_rd_vld", 64'(rd_vld), 64'h0);
    checkOutput("t6_post_dout", 64'(dout), 64'hC0_0000_0700);

    // Wide configuration: full-key vs index-field compare and priority
    tag_a = 48'h1234_5678_9ABC;
    tag_b = tag_a ^ 48'hFF00_0000_0000;
    wr_en2 = 1'b1; wr_adr2 = 5'd20; din2 = tag_a;
    applyStimulus();
    wr_en2 = 1'b1; wr_adr2 = 5'd31; din2 = tag_a;
    applyStimulus();
    wr_en2 = 1'b1; wr_adr2 = 5'd7; din2 = tag_b;
    applyStimulus();
    lookup_en2 = 1'b1; key2 = tag_a[47:6];
    applyStimulus();
    applyStimulus();
    checkOutput("w_match", 64'(match2), 64'h8010_0000);
    checkOutput("w_match_idx", 64'(match_idx2), 64'h8010_0080);
    checkOutput("w_hit_adr", 64'(hit_adr2), 64'd20);
    checkOutput("w_multi", 64'(multi_hit2), 64'h1);
    inv_all2 = 1'b1;
    applyStimulus();
    lookup_en2 = 1'b1; key2 = tag_b[47:6];
    applyStimulus();
    applyStimulus();
    checkOutput("w_inv_all_hit", 64'(hit2), 64'h0);
    wr_en2 = 1'b1; wr_adr2 = 5'd31; din2 = tag_b;
    applyStimulus();
    lookup_en2 = 1'b1; key2 = tag_b[47:6];
    applyStimulus();
    rst = 1'b1;
    applyStimulus();
    rst = 1'b0;
    checkOutput("w_rst_hit", 64'(hit2), 64'h0);
    lookup_en2 = 1'b1; key2 = tag_b[47:6];
    applyStimulus();
    applyStimulus();
    checkOutput("w_post_rst_hit", 64'(hit2), 64'h0);
    checkOutput("w_post_rst_match", 64'(match2), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
